// File: rtl/posit_op_sequencer_pkg.sv
// posit_soc_pkg: shared state type, PIO bit map and NaR helper
// for the glue between the HPS PIO exports and the posit adder.
package posit_soc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_e;

    localparam int STAT_ACK     = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_NAR     = 3;
    localparam int STAT_CNT_LSB = 16;

    localparam int CTRL_REQ = 0;
    localparam int CTRL_CLR = 1;

    localparam int NAR_MAX_W = 64;

    // NaR is the sign bit alone: 1 followed by width-1 zeros.
    function automatic logic [NAR_MAX_W-1:0] nar_pattern(
        input int unsigned width
    );
        logic [NAR_MAX_W-1:0] p;
        p = NAR_MAX_W'(1) << (width - 1);
        return p;
    endfunction

endpackage

// File: rtl/posit_op_sequencer.sv
// posit_op_sequencer: turns level PIO writes into a toggle req/ack
// transaction around the posit adder and publishes result and status.
module posit_op_sequencer
    import posit_soc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LATENCY   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_num1,
    input  logic [WIDTH-1:0] io_num2,
    input  logic [31:0]      io_ctrl,
    output logic [WIDTH-1:0] io_addNum1,
    output logic [WIDTH-1:0] io_addNum2,
    input  logic [WIDTH-1:0] io_addResult,
    output logic [WIDTH-1:0] io_result,
    output logic [31:0]      io_status
);

    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(LATENCY);
    localparam logic [WIDTH-1:0] NAR      = WIDTH'(nar_pattern(WIDTH));

    seq_state_e state_q, state_d;

    logic                 req_seen_q, req_seen_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     op1_q, op1_d;
    logic [WIDTH-1:0]     op2_q, op2_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 ovr_q, ovr_d;
    logic                 nar_q, nar_d;
    logic [CNT_WIDTH-1:0] ops_q, ops_d;

    logic req;
    logic clr;
    logic pending;
    logic ctrl_unused;

    assign req         = io_ctrl[CTRL_REQ];
    assign clr         = io_ctrl[CTRL_CLR];
    assign pending     = req != req_seen_q;
    assign ctrl_unused = ^io_ctrl[31:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_seen_q <= 1'b0;
            cnt_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            res_q      <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            nar_q      <= 1'b0;
            ops_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_seen_q <= req_seen_d;
            cnt_q      <= cnt_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            res_q      <= res_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            nar_q      <= nar_d;
            ops_q      <= ops_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_seen_d = req_seen_q;
        cnt_d      = cnt_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        res_d      = res_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        nar_d      = nar_q;
        ops_d      = ops_q;

        unique case (state_q)
            IDLE: begin
                if (pending) begin
                    op1_d      = io_num1;
                    op2_d      = io_num2;
                    req_seen_d = req;
                    cnt_d      = CNT_INIT;
                    busy_d     = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Any edge seen mid-operation is lost work for software.
                if (pending) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_d   = io_addResult;
                    nar_d   = io_addResult == NAR;
                    ack_d   = req_seen_q;
                    busy_d  = 1'b0;
                    ops_d   = ops_q + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase

        // Clear wins over a same-edge increment or overrun.
        if (clr) begin
            ovr_d = 1'b0;
            ops_d = '0;
        end
    end

    assign io_addNum1 = op1_q;
    assign io_addNum2 = op2_q;
    assign io_result  = res_q;

    always_comb begin
        io_status                                = '0;
        io_status[STAT_ACK]                      = ack_q;
        io_status[STAT_BUSY]                     = busy_q;
        io_status[STAT_OVR]                      = ovr_q;
        io_status[STAT_NAR]                      = nar_q;
        io_status[STAT_CNT_LSB +: CNT_WIDTH]     = ops_q;
    end

endmodule
